// File: rtl/reg_file_pkg.sv
// Shared defaults and address-width helper for the parameterised register file.
package reg_file_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_DEPTH  = 32;

  // At least one address bit, even for one- or two-entry files.
  function automatic int addr_w_f(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/reg_file_scoreboard.sv
// Per-register pending flags: set by sb_set, cleared by a write to the same
// register, with set winning a same-edge collision. Register 0 never pends when ZERO_REG=1.
module reg_file_scoreboard
  import reg_file_pkg::*;
#(
  parameter int DEPTH    = DEF_DEPTH,
  parameter int ZERO_REG = 1,
  localparam int ADDR_W  = addr_w_f(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sb_set,
  input  logic [ADDR_W-1:0] sb_addr,
  input  logic              clr_en,
  input  logic [ADDR_W-1:0] clr_addr,
  output logic [DEPTH-1:0]  pending
);

  logic [DEPTH-1:0] pending_nxt;

  always_comb begin
    pending_nxt = pending;
    for (int i = 0; i < DEPTH; i++) begin
      if (clr_en && (clr_addr == ADDR_W'(i))) pending_nxt[i] = 1'b0;
      // Applied after the clear so a new producer overrides the write.
      if (sb_set && (sb_addr == ADDR_W'(i))) pending_nxt[i] = 1'b1;
    end
    if (ZERO_REG != 0) pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) pending <= '0;
    else     pending <= pending_nxt;
  end

endmodule

// File: rtl/param_reg_file.sv
// Two-read/one-write register file with per-register pending scoreboard.
// Optional same-cycle write-to-read forwarding is enabled by defining RF_BYPASS_EN.
module param_reg_file
  import reg_file_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int ZERO_REG = 1,
  localparam int ADDR_W  = addr_w_f(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rfwe,
  input  logic [ADDR_W-1:0] rfwa,
  input  logic [DATA_W-1:0] rfwd,
  input  logic [ADDR_W-1:0] rfra1,
  input  logic [ADDR_W-1:0] rfra2,
  output logic [DATA_W-1:0] rfrd1,
  output logic [DATA_W-1:0] rfrd2,
  input  logic              sb_set,
  input  logic [ADDR_W-1:0] sb_addr,
  output logic              busy1,
  output logic              busy2,
  output logic              any_busy
);

  logic signed [DATA_W-1:0] regs [DEPTH];
  logic signed [DATA_W-1:0] wd;
  logic [DEPTH-1:0]         pending;
  logic                     wr_ok;
  logic                     clr_en;

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return 32'(a) < 32'(DEPTH);
  endfunction

  function automatic logic is_zero_reg(input logic [ADDR_W-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

`ifdef RF_BYPASS_EN
  function automatic logic byp_hit(input logic [ADDR_W-1:0] a);
    return rfwe && (a == rfwa) && (a != '0) && in_range(a);
  endfunction
`endif

  assign wd     = rfwd;
  assign wr_ok  = rfwe && in_range(rfwa) && !is_zero_reg(rfwa);
  assign clr_en = rfwe && in_range(rfwa);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (wr_ok) begin
      regs[rfwa] <= wd;
    end
  end

  reg_file_scoreboard #(
    .DEPTH    (DEPTH),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk      (clk),
    .rst      (rst),
    .sb_set   (sb_set),
    .sb_addr  (sb_addr),
    .clr_en   (clr_en),
    .clr_addr (rfwa),
    .pending  (pending)
  );

  // Unmapped and hardwired-zero addresses read 0 and never report busy.
  always_comb begin
    rfrd1 = '0;
    busy1 = 1'b0;
    if (in_range(rfra1) && !is_zero_reg(rfra1)) begin
      rfrd1 = regs[rfra1];
      busy1 = pending[rfra1];
    end
`ifdef RF_BYPASS_EN
    if (byp_hit(rfra1)) begin
      rfrd1 = wd;
      busy1 = 1'b0;
    end
`endif
  end

  always_comb begin
    rfrd2 = '0;
    busy2 = 1'b0;
    if (in_range(rfra2) && !is_zero_reg(rfra2)) begin
      rfrd2 = regs[rfra2];
      busy2 = pending[rfra2];
    end
`ifdef RF_BYPASS_EN
    if (byp_hit(rfra2)) begin
      rfrd2 = wd;
      busy2 = 1'b0;
    end
`endif
  end

  assign any_busy = |pending;

endmodule

// File: tb/tb_param_reg_file.sv
// Directed checks of param_reg_file: default build (32x32) and a 16-bit, 24-entry instance.
module tb_param_reg_file;

  logic        clk;
  logic        rst;

  // Default-parameter instance
  logic        a_we, a_sb_set;
  logic [4:0]  a_wa, a_ra1, a_ra2, a_sb_addr;
  logic [31:0] a_wd, a_rd1, a_rd2;
  logic        a_busy1, a_busy2, a_any;

  // DATA_W=16, DEPTH=24 instance
  logic        b_we, b_sb_set;
  logic [4:0]  b_wa, b_ra1, b_ra2, b_sb_addr;
  logic [15:0] b_wd, b_rd1, b_rd2;
  logic        b_busy1, b_busy2, b_any;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_byp;

  param_reg_file dut_a (
    .clk(clk), .rst(rst), .rfwe(a_we), .rfwa(a_wa), .rfwd(a_wd),
    .rfra1(a_ra1), .rfra2(a_ra2), .rfrd1(a_rd1), .rfrd2(a_rd2),
    .sb_set(a_sb_set), .sb_addr(a_sb_addr),
    .busy1(a_busy1), .busy2(a_busy2), .any_busy(a_any)
  );

  param_reg_file #(.DATA_W(16), .DEPTH(24)) dut_b (
    .clk(clk), .rst(rst), .rfwe(b_we), .rfwa(b_wa), .rfwd(b_wd),
    .rfra1(b_ra1), .rfra2(b_ra2), .rfrd1(b_rd1), .rfrd2(b_rd2),
    .sb_set(b_sb_set), .sb_addr(b_sb_addr),
    .busy1(b_busy1), .busy2(b_busy2), .any_busy(b_any)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    a_we = 0; a_wa = 0; a_wd = 0; a_ra1 = 0; a_ra2 = 0; a_sb_set = 0; a_sb_addr = 0;
    b_we = 0; b_wa = 0; b_wd = 0; b_ra1 = 0; b_ra2 = 0; b_sb_set = 0; b_sb_addr = 0;
    tick();
    tick();
    rst = 1'b0;
    a_ra1 = 5; a_ra2 = 31;
    #1;
    check("reset_rd1", a_rd1, 32'h0);
    check("reset_rd2", a_rd2, 32'h0);
    check("reset_any_busy", {31'b0, a_any}, 32'h0);

    // Write r5, mark r6 pending, then reset with competing write/set
    a_we = 1; a_wa = 5; a_wd = 32'hDEADBEEF; a_sb_set = 1; a_sb_addr = 6;
    tick();
    a_we = 0; a_sb_set = 0;
    #1;
    check("wr_r5", a_rd1, 32'hDEADBEEF);
    check("pend_r6_any", {31'b0, a_any}, 32'h1);
    rst = 1; a_we = 1; a_wa = 5; a_wd = 32'h1; a_sb_set = 1; a_sb_addr = 8;
    tick();
    rst = 0; a_we = 0; a_sb_set = 0; a_ra2 = 8;
    #1;
    check("rst_clears_r5", a_rd1, 32'h0);
    check("rst_any_busy", {31'b0, a_any}, 32'h0);
    check("rst_dom_sb_r8", {31'b0, a_busy2}, 32'h0);

    // Hardwired zero register
    a_we = 1; a_wa = 0; a_wd = 32'h12345678;
    tick();
    a_we = 0; a_ra1 = 0;
    #1;
    check("r0_read", a_rd1, 32'h0);
    a_sb_set = 1; a_sb_addr = 0;
    tick();
    a_sb_set = 0;
    #1;
    check("r0_busy1", {31'b0, a_busy1}, 32'h0);
    check("r0_any_busy", {31'b0, a_any}, 32'h0);

    // Scoreboard set then clear by write
    a_sb_set = 1; a_sb_addr = 9;
    tick();
    a_sb_set = 0; a_ra1 = 9; a_ra2 = 9;
    #1;
    check("sb9_busy1", {31'b0, a_busy1}, 32'h1);
    check("sb9_busy2", {31'b0, a_busy2}, 32'h1);
    check("sb9_any", {31'b0, a_any}, 32'h1);
    a_we = 1; a_wa = 9; a_wd = 32'h5;
    tick();
    a_we = 0;
    #1;
    check("wr9_busy1", {31'b0, a_busy1}, 32'h0);
    check("wr9_rd1", a_rd1, 32'h5);
    check("wr9_any", {31'b0, a_any}, 32'h0);

    // Same-edge set and write: data lands, pending stays
    a_sb_set = 1; a_sb_addr = 3; a_we = 1; a_wa = 3; a_wd = 32'hA;
    tick();
    a_sb_set = 0; a_we = 0; a_ra1 = 3;
    #1;
    check("coll_rd1", a_rd1, 32'hA);
    check("coll_busy1", {31'b0, a_busy1}, 32'h1);
    a_we = 1; a_wa = 3; a_wd = 32'hFFFF_FFF0;
    tick();
    a_we = 0;
    #1;
    check("coll_clear_busy", {31'b0, a_busy1}, 32'h0);
    check("neg_data", a_rd1, 32'hFFFF_FFF0);

    // Write-to-read visibility, with or without forwarding
    a_we = 1; a_wa = 7; a_wd = 32'h11;
    tick();
    a_wd = 32'h22; a_ra1 = 7; a_ra2 = 7;
`ifdef RF_BYPASS_EN
    exp_byp = 32'h22;
`else
    exp_byp = 32'h11;
`endif
    #1;
    check("byp_rd2_before", a_rd2, exp_byp);
    check("byp_ports_match", a_rd1, exp_byp);
    tick();
    a_we = 0;
    #1;
    check("byp_rd2_after", a_rd2, 32'h22);
    a_ra1 = 5; a_ra2 = 9;
    #1;
    check("indep_rd1", a_rd1, 32'h0);
    check("indep_rd2", a_rd2, 32'h5);

    // Narrow, non-power-of-two instance
    b_we = 1; b_wa = 23; b_wd = 16'hBEEF;
    tick();
    b_wa = 30; b_wd = 16'h1234; b_sb_set = 1; b_sb_addr = 30;
    tick();
    b_we = 0; b_sb_set = 0; b_ra1 = 23; b_ra2 = 30;
    #1;
    check("b_r23", {16'h0, b_rd1}, 32'h0000BEEF);
    check("b_r30_rd", {16'h0, b_rd2}, 32'h0);
    check("b_r30_busy", {31'b0, b_busy2}, 32'h0);
    check("b_any", {31'b0, b_any}, 32'h0);
    b_ra1 = 14; b_ra2 = 22;
    #1;
    check("b_r14_untouched", {16'h0, b_rd1}, 32'h0);
    check("b_r22_untouched", {16'h0, b_rd2}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
